fmul_radix: RTL and testbench

Parametrised sequential floating-point multiplier for the MIX arithmetic unit, successor to the fixed 4-byte, 3-bit-per-cycle FMUL. The word format is sign, one-byte excess-BIAS exponent, and an FBYTES-byte fraction. The block runs a DIGIT-bits-per-cycle shift-and-add multiply, normalises by whole bytes, and rounds in either nearest-even or truncate mode. It reports overflow and underflow and uses a busy/done handshake. It sits beside the other float units behind the MIX command decoder (C=3).

---
 rtl/fmul_pkg.sv | 28 ++
 rtl/lzb_count.sv | 30 +++
 rtl/fmul_radix.sv | 151 +++++++++++++++
 tb/tb_fmul_radix.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared definitions for the MIX float units: FSM states, default format
// parameters, width helpers and rounding-mode encodings.
package fmul_pkg;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    localparam int DEF_BYTE   = 6;
    localparam int DEF_FBYTES = 4;
    localparam int DEF_DIGIT  = 3;
    localparam int DEF_BIAS   = 32;

    localparam logic RND_NEAR  = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    function automatic int frac_w(input int bw, input int fbytes);
        return bw * fbytes;
    endfunction

    function automatic int word_w(input int bw, input int fbytes);
        return 1 + bw + bw * fbytes;
    endfunction

    // Two extra bits hold the signed, pre-wrap exponent.
    function automatic int exp_w(input int bw);
        return bw + 2;
    endfunction

endpackage

// File: rtl/lzb_count.sv
// Leading-zero-byte counter: k = number of all-zero bytes above the first
// non-zero byte, zero = whole word is zero (k is then 0).
module lzb_count
    import fmul_pkg::*;
#(
    parameter int  BYTE = DEF_BYTE,
    parameter int  NB   = 2 * DEF_FBYTES,
    localparam int KW   = $clog2(NB)
) (
    input  logic [NB*BYTE-1:0] p,
    output logic [KW-1:0]      k,
    output logic               zero
);

    logic found;

    always_comb begin
        k     = '0;
        found = 1'b0;
        for (int j = 0; j < NB; j++) begin
            if (!found && (p[(NB-1-j)*BYTE +: BYTE] != '0)) begin
                k     = KW'(j);
                found = 1'b1;
            end
        end
    end

    assign zero = ~found;

endmodule

// File: rtl/fmul_radix.sv
// Sequential MIX float multiplier: DIGIT-bit shift-and-add, whole-byte
// normalisation, nearest-even or truncate rounding, busy/done handshake.
module fmul_radix
    import fmul_pkg::*;
#(
    parameter int  BYTE   = DEF_BYTE,
    parameter int  FBYTES = DEF_FBYTES,
    parameter int  DIGIT  = DEF_DIGIT,
    parameter int  BIAS   = DEF_BIAS,
    localparam int FRAC   = frac_w(BYTE, FBYTES),
    localparam int W      = word_w(BYTE, FBYTES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         rnd,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic         overflow,
    output logic         underflow
);

    localparam int EW    = exp_w(BYTE);
    localparam int PW    = 2 * FRAC;
    localparam int NB    = 2 * FBYTES;
    localparam int KW    = $clog2(NB);
    localparam int STEPS = FRAC / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << BYTE) - 1);
    localparam logic [FRAC-1:0]      HALF = {1'b1, {(FRAC-1){1'b0}}};

    state_t state_q, state_d;
    logic   load, step, fin;

    logic [FRAC-1:0]        a_q, b_q;
    logic [PW-1:0]          p_q;
    logic                   s_q, rm_q;
    logic signed [EW-1:0]   e_q;
    logic [CW-1:0]          cnt_q;

    logic [W-1:0]           out_q, out_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d, done_q;

    logic [KW-1:0]          k;
    logic                   pzero;
    logic [PW-1:0]          pn;
    logic [FRAC-1:0]        h, r, frac_fin;
    logic [FRAC:0]          h_inc;
    logic                   inc;
    logic signed [EW-1:0]   e_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = MUL;
            end
            MUL: begin
                step = 1'b1;
                if (cnt_q == CW'(STEPS - 1)) state_d = FIN;
            end
            FIN: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            s_q    <= 1'b0;
            rm_q   <= 1'b0;
            e_q    <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (load) begin
                a_q   <= in1[FRAC-1:0];
                b_q   <= in2[FRAC-1:0];
                s_q   <= in1[W-1] ^ in2[W-1];
                e_q   <= EW'(in1[FRAC +: BYTE]) + EW'(in2[FRAC +: BYTE]) - EW'(BIAS);
                rm_q  <= rnd;
                p_q   <= '0;
                cnt_q <= '0;
            end
            // Multiplier digits are consumed MSB-first, so P shifts up each step.
            if (step) begin
                p_q   <= (p_q << DIGIT) + PW'(a_q[FRAC-1 -: DIGIT]) * PW'(b_q);
                a_q   <= a_q << DIGIT;
                cnt_q <= cnt_q + CW'(1);
            end
            if (fin) begin
                out_q <= out_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    lzb_count #(.BYTE(BYTE), .NB(NB)) u_lzb (
        .p    (p_q),
        .k    (k),
        .zero (pzero)
    );

    always_comb begin
        pn       = p_q << (int'(k) * BYTE);
        h        = pn[PW-1:FRAC];
        r        = pn[FRAC-1:0];
        inc      = (rm_q == RND_NEAR) && ((r > HALF) || ((r == HALF) && h[0]));
        h_inc    = {1'b0, h} + {{FRAC{1'b0}}, inc};
        // A carry out of H renormalises to a single leading one-byte.
        e_fin    = e_q - $signed(EW'(k)) + $signed(EW'(h_inc[FRAC]));
        frac_fin = h_inc[FRAC] ? (FRAC'(1) << (FRAC - BYTE)) : h_inc[FRAC-1:0];
        out_d    = {s_q, e_fin[BYTE-1:0], frac_fin};
        ovf_d    = (e_fin > EMAX);
        unf_d    = (e_fin < 0);
        if (pzero) begin
            out_d = {s_q, {(W-1){1'b0}}};
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fmul_radix.sv
// Randomised and directed bench for fmul_radix against a plain-arithmetic
// model of the MIX multiply (normalise by bytes, round, wrap exponent).
module tb_fmul_radix;
    import fmul_pkg::*;

    logic        clk, rst_n, start, rnd;
    logic [30:0] in1, in2, out;
    logic        busy, done, overflow, underflow;

    int n_tests, n_fail;

    fmul_radix dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rnd       (rnd),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] fp(input logic s, input int e, input logic [23:0] f);
        return {s, 6'(e), f};
    endfunction

    // Returns {overflow, underflow, out}.
    function automatic logic [32:0] ref_mul(input logic [30:0] x, input logic [30:0] y,
                                            input logic rm);
        longint unsigned p, h, r;
        int   e;
        logic s;
        s = x[30] ^ y[30];
        p = 64'(x[23:0]) * 64'(y[23:0]);
        if (p == 0) return {2'b00, s, 30'd0};
        e = int'(x[29:24]) + int'(y[29:24]) - 32;
        while (p < (64'd1 << 42)) begin
            p = p << 6;
            e = e - 1;
        end
        h = p >> 24;
        r = p & 64'hFF_FFFF;
        if (!rm && (r > 64'h80_0000 || (r == 64'h80_0000 && h[0]))) h = h + 1;
        if (h == 64'h100_0000) begin
            h = 64'h4_0000;
            e = e + 1;
        end
        return {e > 63, e < 0, s, 6'(e & 63), 24'(h)};
    endfunction

    function automatic logic [30:0] rnd_op();
        logic [23:0] f;
        int sh;
        f  = 24'($urandom);
        sh = $urandom_range(0, 4);
        if (sh == 4) f = '0;
        else         f = f >> (6 * sh);
        return {1'($urandom), 6'($urandom), f};
    endfunction

    task automatic do_op(input logic [30:0] x, input logic [30:0] y, input logic rm,
                         output logic [32:0] res);
        logic [32:0] exp_r;
        int cyc;
        exp_r = ref_mul(x, y, rm);
        @(posedge clk); #1;
        in1 = x; in2 = y; rnd = rm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in1 = 31'($urandom); in2 = 31'($urandom); rnd = 1'($urandom);
        chk("busy_run", busy, 1);
        cyc = 0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 9);
        chk("busy_done", busy, 0);
        res = {overflow, underflow, out};
        chk("result", res, exp_r);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("out_hold", out, exp_r[30:0]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [32:0] res, ea, eb, got;
        logic [30:0] xa, ya, xb, yb;
        int nd, cyc, gap;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; rnd = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst_n = 1'b1;

        do_op(fp(1'b0, 33, 24'o01000000), fp(1'b0, 33, 24'o01000000), RND_NEAR, res);
        chk("one", res, {2'b00, fp(1'b0, 33, 24'o01000000)});
        do_op(fp(1'b0, 32, 24'o40000000), fp(1'b0, 32, 24'o40000003), RND_NEAR, res);
        chk("tie_near_odd", res, {2'b00, fp(1'b0, 32, 24'o20000002)});
        do_op(fp(1'b0, 32, 24'o40000000), fp(1'b0, 32, 24'o40000003), RND_TRUNC, res);
        chk("tie_trunc", res, {2'b00, fp(1'b0, 32, 24'o20000001)});
        do_op(fp(1'b0, 32, 24'o40000000), fp(1'b0, 32, 24'o40000001), RND_NEAR, res);
        chk("tie_near_even", res, {2'b00, fp(1'b0, 32, 24'o20000000)});
        do_op(fp(1'b0, 32, 24'o40000000), fp(1'b0, 32, 24'o40000001), RND_TRUNC, res);
        chk("tie_trunc_even", res, {2'b00, fp(1'b0, 32, 24'o20000000)});
        do_op(fp(1'b0, 63, 24'o40000000), fp(1'b0, 63, 24'o40000000), RND_NEAR, res);
        chk("overflow", res, {2'b10, fp(1'b0, 30, 24'o20000000)});
        do_op(fp(1'b1, 0, 24'o40000000), fp(1'b0, 0, 24'o40000000), RND_NEAR, res);
        chk("underflow", res, {2'b01, fp(1'b1, 32, 24'o20000000)});
        do_op(fp(1'b1, 40, 24'o00000000), fp(1'b0, 35, 24'o12345670), RND_NEAR, res);
        chk("zero", res, {2'b00, fp(1'b1, 0, 24'o00000000)});
        do_op(fp(1'b0, 32, 24'o07777777), fp(1'b0, 32, 24'o10000001), RND_NEAR, res);
        chk("rnd_carry", res, {2'b00, fp(1'b0, 32, 24'o01000000)});
        do_op(fp(1'b0, 32, 24'o07777777), fp(1'b0, 32, 24'o10000001), RND_TRUNC, res);
        chk("rnd_nocarry", res, {2'b00, fp(1'b0, 31, 24'o77777777)});

        // Starts while busy are ignored.
        xa = fp(1'b0, 33, 24'o12345670); ya = fp(1'b1, 31, 24'o76543210);
        xb = fp(1'b0, 40, 24'o11111111); yb = fp(1'b0, 20, 24'o00220011);
        ea = ref_mul(xa, ya, RND_NEAR);
        eb = ref_mul(xb, yb, RND_TRUNC);
        @(posedge clk); #1;
        in1 = xa; in2 = ya; rnd = RND_NEAR; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; got = '0;
        for (int c = 1; c <= 24; c++) begin
            start = (c == 3 || c == 5);
            in1 = xb; in2 = yb; rnd = RND_TRUNC;
            @(posedge clk); #1;
            if (done) begin
                nd++;
                got = {overflow, underflow, out};
            end
        end
        start = 1'b0;
        chk("ign_ndone", nd, 1);
        chk("ign_result", got, ea);

        // Start accepted in the done cycle.
        @(posedge clk); #1;
        in1 = xa; in2 = ya; rnd = RND_NEAR; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_first", {overflow, underflow, out}, ea);
        in1 = xb; in2 = yb; rnd = RND_TRUNC; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (!done && gap < 30) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", gap, 10);
        chk("b2b_second", {overflow, underflow, out}, eb);

        // Reset mid-operation aborts it.
        @(posedge clk); #1;
        in1 = xa; in2 = ya; rnd = RND_NEAR; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out", out, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_unf", underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);
        chk("abort_idle", busy, 0);
        do_op(xa, ya, RND_NEAR, res);

        for (int i = 0; i < 40; i++) begin
            do_op(rnd_op(), rnd_op(), 1'($urandom), res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
